// File: rtl/prog_switch_buffer.sv
// Switch-driven program buffer: assembles instruction words from two switch slices, stores them and replays them.
// Optional define PRGBUF_WRAP_EN makes RUN loop the program instead of halting on the last entry.
module prog_switch_buffer #(
  parameter  int SW_W    = 16,
  parameter  int DEPTH   = 8,
  parameter  int RUN_DIV = 4,
  localparam int DATA_W  = 2 * SW_W,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [SW_W-1:0]   sw_input,
  input  logic [2:0]        sw_control,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [CNT_W-1:0]  count,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              full,
  output logic              empty,
  output logic              sled,
  output logic              err
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_LOAD_LO = 3'd1,
    CMD_LOAD_HI = 3'd2,
    CMD_PUSH    = 3'd3,
    CMD_STEP    = 3'd4,
    CMD_RUN     = 3'd5,
    CMD_REWIND  = 3'd6,
    CMD_CLEAR   = 3'd7
  } cmd_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                err_q, err_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [CNT_W-1:0]    rd_next;
  logic                at_last;
  logic                is_full;

  assign rd_next = CNT_W'(rd_ptr_q) + CNT_W'(1);
  assign at_last = (rd_next == count_q);
  assign is_full = (count_q == DEPTH_C);

  // Command decode, replay divider and state transitions.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    asm_d    = asm_q;
    err_d    = err_q;
    div_d    = div_q;
    mem_we   = 1'b0;
    if (cmd_valid) begin
      // A strobe always wins over a divider tick, so no advance happens here.
      if (state_q == ST_RUN) begin
        case (sw_control)
          CMD_NOP: begin
            div_d = div_q;
          end
          CMD_STEP: begin
            state_d = ST_IDLE;
            div_d   = '0;
          end
          CMD_REWIND: begin
            rd_ptr_d = '0;
            div_d    = '0;
          end
          CMD_CLEAR: begin
            state_d  = ST_IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            asm_d    = '0;
            err_d    = 1'b0;
            div_d    = '0;
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
      end else begin
        case (sw_control)
          CMD_NOP: begin
            state_d = state_q;
          end
          CMD_LOAD_LO: begin
            asm_d[SW_W-1:0] = sw_input;
          end
          CMD_LOAD_HI: begin
            asm_d[DATA_W-1:SW_W] = sw_input;
          end
          CMD_PUSH: begin
            if (is_full) begin
              err_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CNT_W'(1);
            end
          end
          CMD_STEP: begin
            if (rd_next < count_q) begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_RUN: begin
            if (count_q != CNT_W'(0)) begin
              state_d = ST_RUN;
              div_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_REWIND: begin
            rd_ptr_d = '0;
          end
          CMD_CLEAR: begin
            state_d  = ST_IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            asm_d    = '0;
            err_d    = 1'b0;
            div_d    = '0;
          end
          default: begin
            err_d = err_q;
          end
        endcase
      end
    end else if (state_q == ST_RUN) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (at_last) begin
`ifdef PRGBUF_WRAP_EN
          rd_ptr_d = '0;
`else
          state_d = ST_HALT;
`endif
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

  // Control state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      asm_q    <= asm_d;
      err_q    <= err_d;
      div_q    <= div_d;
    end
  end

  // Program storage; contents are intentionally left unreset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem_q[count_q[PTR_W-1:0]] <= asm_q;
    end else begin
      mem_q[count_q[PTR_W-1:0]] <= mem_q[count_q[PTR_W-1:0]];
    end
  end

  assign empty       = (count_q == CNT_W'(0));
  assign full        = is_full;
  assign instr_valid = ~empty;
  assign instruction = empty ? DATA_W'(0) : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign rd_ptr      = rd_ptr_q;
  assign sled        = (state_q == ST_RUN);
  assign err         = err_q;

endmodule
